// File: rtl/tube_write_arbiter.sv
// Round-robin arbiter sharing the slow tube write port between two requesters.
// Each granted write is held on the port for HOLD_CYCLES clocks; a shadow keeps the displayed value.
module tube_write_arbiter #(
    parameter int unsigned HOLD_CYCLES = 2501
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [2:0]  addr0,
    input  logic [31:0] din0,
    output logic        done0,
    input  logic        req1,
    input  logic [2:0]  addr1,
    input  logic [31:0] din1,
    output logic        done1,
    output logic        err,
    output logic        busy,
    output logic        tube_we,
    output logic [2:0]  tube_addr,
    output logic [31:0] tube_din,
    output logic [35:0] shadow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    function automatic logic addr_legal(input logic [2:0] a);
        return (a == 3'b000) || (a == 3'b001);
    endfunction

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic        win_r, win_s;
    logic        rr_ptr_r, rr_ptr_s;
    logic [2:0]  addr_r, addr_s;
    logic [31:0] data_r, data_s;
    logic        ill_r, ill_s;
    logic [35:0] shadow_s;

    // Next-state, grant selection and shadow update
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        win_s    = win_r;
        rr_ptr_s = rr_ptr_r;
        addr_s   = addr_r;
        data_s   = data_r;
        ill_s    = ill_r;
        shadow_s = shadow;
        case (state_r)
            ST_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        win_s = rr_ptr_r;
                    end else begin
                        win_s = req1;
                    end
                    addr_s = win_s ? addr1 : addr0;
                    data_s = win_s ? din1 : din0;
                    if (addr_legal(addr_s)) begin
                        state_s = ST_HOLD;
                        cnt_s   = HOLD_LAST;
                        ill_s   = 1'b0;
                    end else begin
                        state_s = ST_DONE;
                        cnt_s   = 16'd0;
                        ill_s   = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_r == 16'd0) begin
                    state_s = ST_DONE;
                    // Shadow is committed on entry to DONE so it is visible with the done pulse
                    if (addr_r == 3'b000) begin
                        shadow_s[31:0] = data_r;
                    end else begin
                        shadow_s[35:32] = data_r[3:0];
                    end
                end else begin
                    cnt_s = cnt_r - 16'd1;
                end
            end
            ST_DONE: begin
                state_s  = ST_IDLE;
                rr_ptr_s = ~win_r;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            win_r     <= 1'b0;
            rr_ptr_r  <= 1'b0;
            addr_r    <= 3'd0;
            data_r    <= 32'd0;
            ill_r     <= 1'b0;
            shadow    <= 36'd0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            tube_we   <= 1'b0;
            tube_addr <= 3'd0;
            tube_din  <= 32'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            win_r     <= win_s;
            rr_ptr_r  <= rr_ptr_s;
            addr_r    <= addr_s;
            data_r    <= data_s;
            ill_r     <= ill_s;
            shadow    <= shadow_s;
            done0     <= (state_s == ST_DONE) && !win_s;
            done1     <= (state_s == ST_DONE) && win_s;
            err       <= (state_s == ST_DONE) && ill_s;
            busy      <= (state_s != ST_IDLE);
            tube_we   <= (state_s == ST_HOLD);
            tube_addr <= (state_s == ST_HOLD) ? addr_s : 3'd0;
            tube_din  <= (state_s == ST_HOLD) ? data_s : 32'd0;
        end
    end

endmodule

// File: tb/tb_tube_write_arbiter.sv
// Scoreboard bench for tube_write_arbiter: driver pushes expected completions from a
// transaction-level model, an independent monitor checks the tube port and done pulses.
module tb_tube_write_arbiter;

    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [2:0]  addr0, addr1;
    logic [31:0] din0, din1;
    logic        done0, done1, err, busy, tube_we;
    logic [2:0]  tube_addr;
    logic [31:0] tube_din;
    logic [35:0] shadow;

    tube_write_arbiter #(.HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .din0(din0), .done0(done0),
        .req1(req1), .addr1(addr1), .din1(din1), .done1(done1),
        .err(err), .busy(busy), .tube_we(tube_we), .tube_addr(tube_addr),
        .tube_din(tube_din), .shadow(shadow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          id;
        bit          err;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [35:0] shadow;
        int          gap;
    } exp_t;

    exp_t        sb[$];
    int          nchk = 0;
    int          nerr = 0;
    logic [35:0] shadow_m = 36'd0;
    bit          rr_m = 1'b0;

    function automatic bit legal(input logic [2:0] a);
        return a <= 3'd1;
    endfunction

    function automatic int latency(input logic [2:0] a);
        return legal(a) ? H + 1 : 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic flag(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Model: completions happen in issue order; each one advances the round-robin pointer
    function automatic void model_push(input bit id, input logic [2:0] a, input logic [31:0] d, input int gap);
        exp_t e;
        if (a == 3'b000) shadow_m[31:0] = d;
        else if (a == 3'b001) shadow_m[35:32] = d[3:0];
        e.id = id; e.err = !legal(a); e.addr = a; e.data = d;
        e.shadow = shadow_m; e.gap = gap;
        rr_m = ~id;
        sb.push_back(e);
    endfunction

    function automatic logic [2:0] rand_addr();
        int r;
        r = $urandom_range(0, 5);
        if (r < 4) return 3'(r % 2);
        return 3'($urandom_range(2, 7));
    endfunction

    // Monitor
    initial begin
        int   hold;
        int   cyc;
        int   last_done;
        exp_t e;
        hold = 0; cyc = 0; last_done = -1000;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                hold = 0;
                check("reset_outputs", {tube_we, busy, done0, done1, err, tube_addr, tube_din}, 64'd0);
                check("reset_shadow", shadow, 64'd0);
            end else begin
                if (tube_we) begin
                    hold++;
                    if (sb.size() == 0) flag("unexpected_tube_we");
                    else check("tube_port", {tube_addr, tube_din}, {sb[0].addr, sb[0].data});
                end else begin
                    check("idle_port_zero", {tube_addr, tube_din}, 64'd0);
                end
                check("busy", busy, tube_we | done0 | done1);
                if (err && !(done0 | done1)) flag("err_without_done");
                if (done0 | done1) begin
                    if (sb.size() == 0) begin
                        flag("unexpected_done");
                    end else begin
                        e = sb.pop_front();
                        check("done_id", {done0, done1}, e.id ? 64'd1 : 64'd2);
                        check("err", err, e.err);
                        check("shadow", shadow, e.shadow);
                        check("hold_len", hold, e.err ? 0 : H);
                        if (e.gap > 0) check("done_gap", cyc - last_done, e.gap);
                    end
                    hold = 0;
                    last_done = cyc;
                end
            end
        end
    end

    task automatic set_req(input bit id, input bit v, input logic [2:0] a, input logic [31:0] d);
        if (id) begin req1 = v; addr1 = a; din1 = d; end
        else begin req0 = v; addr0 = a; din0 = d; end
    endtask

    task automatic single(input bit id, input logic [2:0] a, input logic [31:0] d, input bit scramble);
        int n;
        bit seen;
        model_push(id, a, d, 0);
        set_req(id, 1'b1, a, d);
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (scramble && n == 2) begin
                if (id) din1 = (d == 32'hFFFFFFFF) ? 32'd0 : 32'hFFFFFFFF;
                else din0 = (d == 32'hFFFFFFFF) ? 32'd0 : 32'hFFFFFFFF;
            end
            seen = id ? done1 : done0;
        end
        check("latency", n, latency(a));
        set_req(id, 1'b0, a, d);
    endtask

    task automatic both(input logic [2:0] a0, input logic [31:0] d0,
                        input logic [2:0] a1, input logic [31:0] d1, input int ngr);
        bit ord[$];
        bit first;
        bit id;
        bit who;
        bit still;
        int cnt;
        int n;
        first = rr_m;
        for (int k = 0; k < ngr; k++) begin
            id = first ^ k[0];
            ord.push_back(id);
            model_push(id, id ? a1 : a0, id ? d1 : d0, (k == 0) ? 0 : 1 + latency(id ? a1 : a0));
        end
        req0 = 1'b1; addr0 = a0; din0 = d0;
        req1 = 1'b1; addr1 = a1; din1 = d1;
        cnt = 0; n = 0;
        while (cnt < ngr && n < 400) begin
            @(negedge clk);
            n++;
            if (done0 | done1) begin
                who = done1;
                check("grant_order", who, ord[cnt]);
                cnt++;
                still = 1'b0;
                for (int j = cnt; j < ngr; j++) if (ord[j] == who) still = 1'b1;
                if (!still) begin
                    if (who) req1 = 1'b0;
                    else req0 = 1'b0;
                end
            end
        end
        if (cnt < ngr) flag("both_timeout");
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        sb.delete();
        shadow_m = 36'd0;
        rr_m = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("post_reset", {tube_we, busy, done0, done1, err}, 64'd0);
        check("post_reset_shadow", shadow, 64'd0);
    endtask

    initial begin
        logic [2:0]  a0, a1;
        logic [31:0] d0, d1;
        int          mode;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 3'd0; addr1 = 3'd0; din0 = 32'd0; din1 = 32'd0;
        repeat (3) @(negedge clk);
        do_reset();

        single(1'b0, 3'b000, 32'h12345678, 1'b1);
        check("shadow_after_first", shadow, 36'h0_12345678);
        repeat (2) @(negedge clk);

        do_reset();
        d0 = $urandom;
        both(3'b000, d0, 3'b001, 32'h0000000A, 2);
        check("shadow_after_pair", shadow, {4'hA, d0});
        repeat (2) @(negedge clk);

        both(rand_addr(), $urandom, 3'b001, $urandom, 4);
        repeat (2) @(negedge clk);

        single(1'b1, 3'b101, $urandom, 1'b0);
        repeat (2) @(negedge clk);

        // Abandon a write in the middle of its hold window
        d0 = $urandom;
        model_push(1'b0, 3'b000, d0, 0);
        set_req(1'b0, 1'b1, 3'b000, d0);
        repeat (2) @(negedge clk);
        check("mid_hold_we", tube_we, 1'b1);
        do_reset();
        @(negedge clk);
        check("after_abort_shadow", shadow, 64'd0);
        single(1'b0, 3'b001, $urandom, 1'b0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 2);
            a0 = rand_addr(); a1 = rand_addr();
            d0 = $urandom; d1 = $urandom;
            if (mode == 2) both(a0, d0, a1, d1, $urandom_range(2, 3));
            else single(mode[0], mode[0] ? a1 : a0, mode[0] ? d1 : d0, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/tube_write_arbiter.md
# tube_write_arbiter

Shares the digital-tube device's write port between two bus masters: requester 0 (CPU bridge) and requester 1 (secondary master, e.g. timer/status unit). The tube device only samples its write port once per internal prescaler period (2501 clocks), so this block serialises requests with round-robin priority. It holds the granted write stable on the tube port long enough to guarantee capture, then returns a completion pulse. It also keeps a shadow copy of the 36-bit displayed value for read-back without touching the slow device.

## Interface
- HOLD_CYCLES, 2501: cycles tube_we/addr/din are held per write; must be ≥ tube prescaler period; legal range 1..65535.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req0  in  1  requester 0 write request (level, held until done0)
- addr0  in  3  requester 0 register address
- din0  in  32  requester 0 write data
- done0  out  1  one-cycle completion pulse for requester 0
- req1, addr1, din1, done1: same as above for requester 1
- err  out  1  one-cycle pulse coincident with done* when the completed request had an illegal address
- busy  out  1  high whenever state ≠ IDLE
- tube_we  out  1  write enable to tube device
- tube_addr  out  3  address to tube device
- tube_din  out  32  data to tube device
- shadow  out  36  {hi nibble, lo word} last value successfully written

## Operation
- Legal addresses: 3'b000 → low 32 bits; 3'b001 → high nibble (din[3:0]). All others illegal.
- FSM states: IDLE, HOLD, DONE.
- IDLE: if any req high, pick winner: if both high, winner = rr_ptr; else the single requester. Latch winner's addr/din and winner id. Legal addr → HOLD with hold counter = HOLD_CYCLES-1. Illegal addr → DONE with err flag set, no tube_we.
- HOLD: tube_we=1, tube_addr/tube_din = latched values; counter decrements each cycle; at counter==0 → DONE.
- DONE: done[winner]=1 for exactly this cycle; err=1 if flagged; for legal writes update shadow (lo ← data for 000, hi ← data[3:0] for 001); rr_ptr ← other requester; → IDLE.
- Requester inputs are ignored outside IDLE; changes to addr/din during HOLD do not affect tube_din.
- A req still high in the IDLE cycle after done is a new request.
- tube_addr/tube_din are 0 when tube_we=0.

## Timing
- Reset values: state=IDLE, rr_ptr=0, done0=done1=err=busy=tube_we=0, tube_addr=0, tube_din=0, shadow=0.
- Reset mid-operation: next edge forces all of the above; the in-flight write is abandoned, no done pulse, shadow unchanged from reset (0).
- Legal request seen in IDLE at cycle t: tube_we high cycles t+1..t+HOLD_CYCLES; done/shadow update at t+HOLD_CYCLES+1; next grant at earliest t+HOLD_CYCLES+2.
- Illegal request at cycle t: done+err at t+1, tube_we never asserted; IDLE at t+2.
- busy high from t+1 through done cycle inclusive.
- Simultaneous req0/req1 in IDLE: rr_ptr winner; loser waits and is served next grant (no starvation).
- HOLD_CYCLES counter is 16 bits; no wrap within a hold.

## Test plan
- HOLD_CYCLES=4; req0, addr0=000, din0=0x12345678 at t=0 → tube_we high t=1..4 with tube_din=0x12345678; done0 at t=5; shadow=0x0_12345678.
- After reset, req0 and req1 both high (addr 000 / 001, din1=0xA) → requester 0 served first, then requester 1; shadow ends 0xA_(req0 data); done0 precedes done1 by HOLD_CYCLES+2 cycles.
- Both req held continuously for 4 grants → grants alternate 0,1,0,1.
- req1 with addr1=3'b101 → done1+err at t+1, tube_we stays 0, shadow unchanged.
- Change din0 to 0xFFFFFFFF mid-HOLD → tube_din keeps the latched value; shadow gets the latched value.
- Assert reset during HOLD → next cycle tube_we=0, busy=0, no done pulse, shadow=0; a subsequent request completes normally.
